mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Sequences every access to the 64x32 word memory and shares its single port between
//  instruction fetch (IF) and data (D) requesters with round-robin priority.
//  Drives the memory's 7-bit address (bit 6 = write enable, bits 5:0 = word index) and
//  its dataIn bus. Captures dataOut on MFC and returns it with a one-cycle ack pulse.
//  Asserts bit 6 for exactly one cycle per write, so no write is ever repeated or spurious.
// PARAMETERS
//  AW       6    word-address width (64 words)
//  DW       32   data width
//  TIMEOUT  15   max cycles in WAIT without MFC before the access is abandoned (>=1)
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst_n       in   1    reset, asynchronous, active-low
//  if_req      in   1    fetch request (read only)
//  if_addr     in   AW   fetch word address
//  if_ack      out  1    one-cycle pulse: fetch access complete
//  if_rdata    out  DW   fetch read data, valid with if_ack, held until next if_ack
//  d_req       in   1    data request
//  d_we        in   1    1 = write, 0 = read
//  d_addr      in   AW   data word address
//  d_wdata     in   DW   write data
//  d_ack       out  1    one-cycle pulse: data access complete
//  d_rdata     out  DW   data read data, valid with d_ack, held until next d_ack (unchanged on writes)
//  mem_addr    out  AW+1 to memory address: {we, index}
//  mem_din     out  DW   to memory dataIn
//  mem_dout    in   DW   from memory dataOut
//  mem_mfc     in   1    memory function complete
//  busy        out  1    state != IDLE
//  timeout_err out  1    sticky: some access hit TIMEOUT; cleared only by reset
// BEHAVIOUR
//  - All outputs registered or decoded from state; no combinational input->output path.
//  - Reset (rst_n=0, immediate): state=IDLE, mem_addr=0, mem_din=0, acks=0, rdata regs=0,
//    timeout_err=0, wait counter=0, last_grant=D (so IF wins the first tie).
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: mem_addr=0. Sample reqs. If exactly one is high, grant it. If both are high,
//    grant the port not in last_grant. Latch addr, we (0 for IF) and wdata; go to ISSUE.
//  - ISSUE (1 cycle): mem_addr={we,addr}, mem_din=wdata. Counter cleared. Go to WAIT.
//  - WAIT: mem_addr={1'b0,addr}, so the write bit is cleared after one cycle; mem_din is held.
//    - mem_mfc=1: capture mem_dout into the granted port's rdata (reads only); go to RESP.
//    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with mfc still 0:
//      set timeout_err, load rdata=0 (reads), go to RESP.
//  - RESP (1 cycle): the granted port's ack=1. last_grant <= granted port. mem_addr=0. Go to IDLE.
//  - Minimum latency: req sampled at edge k, ack high in cycle k+3 (MFC already 1).
//    Throughput: one access per 4 cycles.
//  - Handshake: a requester holds req until it sees ack. It must drop req at the edge after
//    ack; if req is still high in IDLE, that is a new access.
//  - Operands are latched in IDLE. Changing or dropping req mid-access does not abort it;
//    the ack is still issued.
//  - Both requesters continuously active: grants strictly alternate IF, D, IF, D.
//  - Reset mid-access (any state): abandoned at once, no ack, mem_addr[6]=0 immediately.
// TESTING
//  1. Reset; IF read addr 5, mem_dout=32'hDEADBEEF, mfc=1 -> if_ack 3 edges after req,
//     if_rdata=DEADBEEF, mem_addr[6] never 1.
//  2. D write addr 6'h3F, wdata 32'h12345678 -> mem_addr=7'h7F for exactly 1 cycle, then 7'h3F;
//     mem_din=12345678; d_ack pulse; d_rdata unchanged.
//  3. if_req and d_req both high continuously from reset -> acks IF,D,IF,D;
//     IF addr 1 / D addr 2 visible on mem_addr alternately.
//  4. mfc held 0, TIMEOUT=15 -> ack 15 WAIT cycles after ISSUE, rdata=0,
//     timeout_err=1 and still 1 after the next good access.
//  5. rst_n low during WAIT of a D write -> mem_addr=0 and busy=0 at once, no d_ack;
//     after release an IF read of addr 9 completes normally.
//  6. mfc rises 4 cycles into WAIT with mem_dout=32'hCAFE0001 -> d_ack in the following cycle,
//     d_rdata=CAFE0001.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/D arbiter sequencing a single-port 64x32 word memory
module mem_port_arbiter #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_mfc,
  output logic          busy,
  output logic          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_d_q, gnt_d_d;
  logic            last_d_q, last_d_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            terr_q, terr_d;
  logic            pick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_d_q    <= 1'b0;
      last_d_q   <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      last_d_q   <= last_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d_d    = gnt_d_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    terr_d     = terr_q;
    pick_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On a tie the port that did not win last time gets the grant.
          pick_d  = d_req && (!if_req || !last_d_q);
          gnt_d_d = pick_d;
          addr_d  = pick_d ? d_addr : if_addr;
          we_d    = pick_d & d_we;
          wdata_d = pick_d ? d_wdata : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_mfc) begin
          if (!we_q) begin
            if (gnt_d_q) d_rdata_d = mem_dout;
            else         if_rdata_d = mem_dout;
          end
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          terr_d = 1'b1;
          if (!we_q) begin
            if (gnt_d_q) d_rdata_d = '0;
            else         if_rdata_d = '0;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        last_d_d = gnt_d_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write bit is only ever set in ISSUE, so each write strobes exactly once.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      ISSUE:   mem_addr = {we_q, addr_q};
      WAIT:    mem_addr = {1'b0, addr_q};
      default: mem_addr = '0;
    endcase
  end

  assign mem_din     = wdata_q;
  assign if_ack      = (state_q == RESP) && !gnt_d_q;
  assign d_ack       = (state_q == RESP) && gnt_d_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule
